// File: rtl/fifo_arb_ctrl.sv
// fifo_arb_ctrl
// Sequencing and arbitration controller for a flagless sync_fifo buffer.
// Two write requesters (A, B) share the FIFO. One consumer reads from it.
// The block tracks occupancy and drives the FIFO's wr_en, rd_en and data_in.
// It also qualifies the FIFO's registered read data with dout_valid.
// A flush pulse drains the buffer between filter iterations.
//
// Build option:
//   FIFO_ARB_RR_EN defined   -> round-robin arbitration between A and B
//   FIFO_ARB_RR_EN undefined -> fixed priority, A wins on contention
//
// Reset: sys_rst is synchronous and active-high. The FIFO's sys_rst_n is
// tied to ~sys_rst at integration, so the FIFO pointers reset together
// with this block.

module fifo_arb_ctrl #(
    parameter int DATA_LEN   = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic                  a_req,
    input  logic [DATA_LEN-1:0]   a_data,
    output logic                  a_gnt,
    input  logic                  b_req,
    input  logic [DATA_LEN-1:0]   b_data,
    output logic                  b_gnt,
    input  logic                  rd_req,
    input  logic                  flush,
    output logic                  fifo_wr_en,
    output logic [DATA_LEN-1:0]   fifo_data_in,
    output logic                  fifo_rd_en,
    input  logic [DATA_LEN-1:0]   fifo_data_out,
    output logic [DATA_LEN-1:0]   dout,
    output logic                  dout_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  flushing
);

    // Occupancy value that means "every FIFO slot holds a word".
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  dout_valid_reg;
    logic                  dout_valid_next;

    // Arbitration result before the full/state/reset qualification.
    logic                  a_win;
    logic                  b_win;
    // Writes may be granted only in RUN, outside reset, with room left.
    logic                  wr_allow;
    logic                  full_int;
    logic                  empty_int;

    assign full_int  = (count_reg == FULL_COUNT);
    assign empty_int = (count_reg == '0);

`ifdef FIFO_ARB_RR_EN
    // 1 means B was the last requester granted, so A wins the next contention.
    logic last_b_reg;

    // Remember the last winner. Cycles without a grant leave it alone.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            last_b_reg <= 1'b1;
        end else if (a_gnt | b_gnt) begin
            last_b_reg <= b_gnt;
        end
    end

    // On contention the requester that did not win last time is chosen.
    always_comb begin
        a_win = a_req & (~b_req | last_b_reg);
        b_win = b_req & (~a_req | ~last_b_reg);
    end
`else
    // Fixed priority: B is only chosen when A is idle.
    always_comb begin
        a_win = a_req;
        b_win = b_req & ~a_req;
    end
`endif

    // No write is granted when full, even if a read happens in the same cycle.
    // Otherwise the FIFO's equal-address bypass would return the new word
    // instead of the old one.
    assign wr_allow = ~sys_rst & (state_reg == ST_RUN) & ~full_int;

    // Grants, FIFO strobes and next state. Every output has a default first.
    always_comb begin
        state_next      = state_reg;
        a_gnt           = 1'b0;
        b_gnt           = 1'b0;
        fifo_rd_en      = 1'b0;
        dout_valid_next = 1'b0;

        case (state_reg)
            ST_RUN: begin
                a_gnt      = wr_allow & a_win;
                b_gnt      = wr_allow & b_win;
                // A read is never issued when empty. A write in the same
                // cycle does not change this, because the word is not
                // stored until the next edge.
                fifo_rd_en = ~sys_rst & rd_req & ~empty_int;
                if (flush) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Drain without the consumer. These words are discarded.
                fifo_rd_en = ~sys_rst & ~empty_int;
                // Leave in the cycle after the one where the buffer is empty.
                if (empty_int) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        // Only words read in RUN are handed to the consumer.
        dout_valid_next = fifo_rd_en & (state_reg == ST_RUN);
    end

    // Occupancy tracking. A write and a read together leave the count unchanged.
    always_comb begin
        count_next = count_reg;
        case ({fifo_wr_en, fifo_rd_en})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // State, occupancy and read-valid registers.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_reg      <= ST_RUN;
            count_reg      <= '0;
            dout_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            dout_valid_reg <= dout_valid_next;
        end
    end

    // FIFO write port. data_in defaults to B's word when no grant is active.
    assign fifo_wr_en   = a_gnt | b_gnt;
    assign fifo_data_in = a_gnt ? a_data : b_data;

    // Status and consumer outputs.
    assign dout       = fifo_data_out;
    assign dout_valid = dout_valid_reg;
    assign count      = count_reg;
    assign full       = full_int;
    assign empty      = empty_int;
    assign flushing   = (state_reg == ST_FLUSH);

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// tb_fifo_arb_ctrl
// Randomized and directed stimulus for fifo_arb_ctrl.
// A small FIFO stand-in holds the buffer contents. A queue-based
// reference model predicts every output each cycle.
// Compile with or without FIFO_ARB_RR_EN to match the DUT build.

module tb_fifo_arb_ctrl;

    localparam int DATA_LEN   = 8;
    localparam int DEPTH      = 8;
    localparam int ADDR_WIDTH = 3;

    logic                clk;
    logic                sys_rst;
    logic                a_req, b_req, rd_req, flush;
    logic [7:0]          a_data, b_data;
    logic                a_gnt, b_gnt;
    logic                fifo_wr_en, fifo_rd_en;
    logic [7:0]          fifo_data_in, fifo_data_out;
    logic [7:0]          dout;
    logic                dout_valid;
    logic [3:0]          count;
    logic                full, empty, flushing;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    fifo_arb_ctrl #(
        .DATA_LEN   (DATA_LEN),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk           (clk),
        .sys_rst       (sys_rst),
        .a_req         (a_req),
        .a_data        (a_data),
        .a_gnt         (a_gnt),
        .b_req         (b_req),
        .b_data        (b_data),
        .b_gnt         (b_gnt),
        .rd_req        (rd_req),
        .flush         (flush),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_data_in  (fifo_data_in),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_data_out (fifo_data_out),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .flushing      (flushing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flagless sync FIFO stand-in with registered read data; reset tied to ~sys_rst.
    logic [7:0] fmem [DEPTH];
    logic [2:0] fwp, frp;
    always @(posedge clk) begin
        if (sys_rst) begin
            fwp           <= '0;
            frp           <= '0;
            fifo_data_out <= '0;
        end else begin
            if (fifo_wr_en) begin
                fmem[fwp] <= fifo_data_in;
                fwp       <= fwp + 3'd1;
            end
            if (fifo_rd_en) begin
                fifo_data_out <= fmem[frp];
                frp           <= frp + 3'd1;
            end
        end
    end

    // Reference model state.
    logic [7:0] mq[$];
    logic       m_flush  = 1'b0;
    logic       m_last_b = 1'b1;
    logic       m_dv     = 1'b0;
    logic [7:0] m_dout   = 8'h00;
    logic       chk_en   = 1'b0;
    logic       e_ag, e_bg, e_rd;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            failures_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic cyc(input logic ar, input logic [7:0] ad, input logic br, input logic [7:0] bd,
                       input logic rr, input logic fl, input logic rs);
        logic nf;
        logic [7:0] pd;
        a_req = ar; a_data = ad; b_req = br; b_data = bd;
        rd_req = rr; flush = fl; sys_rst = rs;
        @(negedge clk);
        e_ag = 1'b0; e_bg = 1'b0; e_rd = 1'b0;
        if (!rs) begin
            if (!m_flush) begin
                if (mq.size() < DEPTH) begin
                    if (ar && br) begin
`ifdef FIFO_ARB_RR_EN
                        e_ag = m_last_b;
                        e_bg = !m_last_b;
`else
                        e_ag = 1'b1;
`endif
                    end else begin
                        e_ag = ar;
                        e_bg = br;
                    end
                end
                e_rd = rr && (mq.size() != 0);
            end else begin
                e_rd = (mq.size() != 0);
            end
        end
        if (chk_en) begin
            check_val("a_gnt",      32'(a_gnt),        32'(e_ag));
            check_val("b_gnt",      32'(b_gnt),        32'(e_bg));
            check_val("wr_en",      32'(fifo_wr_en),   32'(e_ag | e_bg));
            check_val("data_in",    32'(fifo_data_in), 32'(e_ag ? ad : bd));
            check_val("rd_en",      32'(fifo_rd_en),   32'(e_rd));
            check_val("count",      32'(count),        32'(mq.size()));
            check_val("full",       32'(full),         32'(mq.size() == DEPTH));
            check_val("empty",      32'(empty),        32'(mq.size() == 0));
            check_val("flushing",   32'(flushing),     32'(m_flush));
            check_val("dout_valid", 32'(dout_valid),   32'(m_dv));
            check_val("dout",       32'(dout),         32'(m_dout));
        end
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_flush  = 1'b0;
            m_last_b = 1'b1;
            m_dv     = 1'b0;
            m_dout   = 8'h00;
        end else begin
            nf   = m_flush ? (mq.size() != 0) : fl;
            m_dv = e_rd && !m_flush;
            if (e_rd) begin
                pd     = mq.pop_front();
                m_dout = pd;
                if (!m_flush) $display("read  0x%02h count=%0d", pd, mq.size());
            end
            if (e_ag) begin
                mq.push_back(ad);
                $display("write A 0x%02h count=%0d", ad, mq.size());
            end else if (e_bg) begin
                mq.push_back(bd);
                $display("write B 0x%02h count=%0d", bd, mq.size());
            end
            if (e_ag || e_bg) m_last_b = e_bg;
            m_flush = nf;
        end
        chk_en = 1'b1;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr_a(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd1();
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic rst1();
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) rd1();
    endtask

    initial begin
        logic [7:0] exp_order [4];
        int n;

        // Reset and idle: requests high during reset, low afterwards.
        cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1);
        idle();
        idle();
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_empty", 32'(empty), 32'd1);

        // Fill to full, then try to write 0x09 while reading.
        for (int i = 1; i <= 8; i++) wr_a(8'(i));
        check_val("fill_full", 32'(full), 32'd1);
        cyc(1'b1, 8'h09, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_val("ovf_dout", 32'(dout), 32'h01);
        check_val("ovf_valid", 32'(dout_valid), 32'd1);
        check_val("ovf_count", 32'(count), 32'd7);
        drain();

        // Contention starts from reset, so the arbiter pointer is at its reset value.
        rst1();
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 8'(8'hA0 + i), 1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
`ifdef FIFO_ARB_RR_EN
        exp_order[0] = 8'hA0; exp_order[1] = 8'hB1; exp_order[2] = 8'hA2; exp_order[3] = 8'hB3;
`else
        exp_order[0] = 8'hA0; exp_order[1] = 8'hA1; exp_order[2] = 8'hA2; exp_order[3] = 8'hA3;
`endif
        for (int k = 0; k < 4; k++) begin
            rd1();
            check_val("contend_order", 32'(dout), 32'(exp_order[k]));
        end
        idle();

        // Simultaneous read and write at count 3.
        for (int i = 0; i < 3; i++) wr_a(8'(8'h31 + i));
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h34 + i), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_val("rw_count", 32'(count), 32'd3);
        drain();

        // Flush with 5 words while A keeps requesting.
        for (int i = 0; i < 5; i++) wr_a(8'(8'h41 + i));
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (flushing && n < 20) begin
            cyc(1'b1, 8'hEE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check_val("flush_len", 32'(n), 32'd6);
        check_val("flush_count", 32'(count), 32'd0);
        wr_a(8'h55);
        rd1();
        check_val("post_flush_dout", 32'(dout), 32'h55);

        // Reset in the middle of a flush.
        for (int i = 0; i < 4; i++) wr_a(8'(8'h61 + i));
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle();
        idle();
        rst1();
        check_val("midrst_flushing", 32'(flushing), 32'd0);
        check_val("midrst_count", 32'(count), 32'd0);
        wr_a(8'h77);
        rd1();
        check_val("midrst_dout", 32'(dout), 32'h77);

        // Random traffic with occasional flushes and resets.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 99) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
